// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: idle/training symbol, transmit FSM states and
// a byte picker used by the word-to-byte stage.
package pcie_phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;

  typedef enum logic [1:0] {
    TRAIN = 2'd0,
    IDLE  = 2'd1,
    SEND  = 2'd2
  } tx_state_t;

  // Byte sel of a word, MSB first: sel = 0 returns word[31:24].
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_word_to_byte_if.sv
// Word-in / byte-out bus of the transmit word-to-byte stage.
//   data_in   [31:0]  word from upstream, [31:24] sent first
//   valid_in          data_in valid
//   ready_out         stage can accept a word this cycle
//   data_out  [7:0]   byte to serializer (COM when idle)
//   valid_out         data_out carries payload
// master: upstream/test side, slave: the stage itself.
interface tx_word_to_byte_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;

  modport master (output data_in, valid_in,
                  input  ready_out, data_out, valid_out);
  modport slave  (input  data_in, valid_in,
                  output ready_out, data_out, valid_out);
endinterface

// File: rtl/tx_word_to_byte_fifo.sv
// word_fifo2: 2-entry, 32-bit synchronous FIFO with its own pointers.
//   clk_4f, reset  clock and synchronous active-high reset
//   push, din      write din at the tail (caller guarantees count < 2)
//   pop            drop the head (caller guarantees count > 0)
//   dout           current head word
//   count [1:0]    number of stored words, 0..2
module word_fifo2 (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [1:0]  count
);

  logic [31:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is left unreset; count/pointers alone decide what is valid.
  always_ff @(posedge clk_4f) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/tx_word_to_byte.sv
// Transmit word-to-byte stage: buffers 32-bit words in a 2-entry FIFO and
// emits one registered byte per clk_4f cycle, MSB first. Drives COM with
// valid_out = 0 during training and whenever no word is queued.
//   clk_4f   byte clock
//   reset    synchronous, active-high
//   bus      tx_word_to_byte_if.slave (data_in/valid_in/ready_out in,
//            data_out/valid_out to the serializer)
// Parameters: TRAIN_BYTES COM-only cycles after reset, COM idle symbol.
module tx_word_to_byte
  import pcie_phy_pkg::*;
#(
  parameter int         TRAIN_BYTES = 4,
  parameter logic [7:0] COM         = COM_SYM
) (
  input  logic               clk_4f,
  input  logic               reset,
  tx_word_to_byte_if.slave   bus
);

  localparam int CNT_W = (TRAIN_BYTES > 0) ? $clog2(TRAIN_BYTES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TRAIN_BYTES);

  tx_state_t        state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] train_cnt_q, train_cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;

  logic        push, pop, ready;
  logic [31:0] head;
  logic [1:0]  count;

  // Ready comes from registers only, so upstream never sees a comb loop.
  assign ready = (state_q != TRAIN) && (count < 2'd2);
  assign push  = bus.valid_in && ready;

  word_fifo2 u_fifo (
    .clk_4f (clk_4f),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (bus.data_in),
    .dout   (head),
    .count  (count)
  );

  always_ff @(posedge clk_4f) begin
    if (reset) state_q <= TRAIN;
    else       state_q <= state_d;
  end

  // A word is popped on its last byte; SEND continues without a bubble when
  // another word is already queued or arrives on that same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TRAIN:   if (train_cnt_q == '0) state_d = IDLE;
      IDLE:    if (count != 2'd0) state_d = SEND;
      SEND:    if ((sel_q == 2'd3) && !((count == 2'd2) || push)) state_d = IDLE;
      default: state_d = TRAIN;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    train_cnt_d = train_cnt_q;
    sel_d       = sel_q;
    data_out_d  = COM;
    valid_out_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      TRAIN: begin
        sel_d = 2'd0;
        if (train_cnt_q != '0) train_cnt_d = train_cnt_q - CNT_W'(1);
      end
      IDLE: begin
        sel_d = 2'd0;
        if (count != 2'd0) begin
          data_out_d  = pick_byte(head, 2'd0);
          valid_out_d = 1'b1;
          sel_d       = 2'd1;
        end
      end
      SEND: begin
        data_out_d  = pick_byte(head, sel_q);
        valid_out_d = 1'b1;
        sel_d       = sel_q + 2'd1;   // wraps 3 -> 0 with the pop
        pop         = (sel_q == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      sel_q       <= 2'd0;
      train_cnt_q <= CNT_INIT;
      data_out_q  <= COM;
      valid_out_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      train_cnt_q <= train_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.ready_out = ready;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;

endmodule
